// File: rtl/memory_dp_clr.sv
// Simple-dual-port RAM: lane-masked write port, registered read port, hardware clear sweep.
// Build option MEM_BYPASS_EN: same-address read returns write-first merged data (default read-first).
module memory_dp_clr #(
    parameter int unsigned     WORD      = 8,
    parameter int unsigned     SIZE      = 256,
    parameter int unsigned     LANES     = 1,
    parameter logic [WORD-1:0] CLEAR_VAL = '0,
    localparam int unsigned    ADR_SIZE  = (SIZE > 1) ? $clog2(SIZE) : 1
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                clear_i,
    output logic                busy_o,
    input  logic                wr_i,
    input  logic [ADR_SIZE-1:0] wr_adr_i,
    input  logic [LANES-1:0]    wr_be_i,
    input  logic [WORD-1:0]     wr_data_i,
    input  logic                rd_i,
    input  logic [ADR_SIZE-1:0] rd_adr_i,
    output logic [WORD-1:0]     rd_data_o,
    output logic                rd_valid_o
);

    localparam int unsigned LW = WORD / LANES;
    // One extra bit so SIZE itself is representable for the range compare.
    localparam logic [ADR_SIZE:0]   SIZE_W = SIZE[ADR_SIZE:0];
    localparam logic [ADR_SIZE-1:0] LAST   = ADR_SIZE'(SIZE - 1);

    typedef enum logic [0:0] {StIdle, StClear} state_e;

    state_e              state_q, state_d;
    logic [ADR_SIZE-1:0] cnt_q, cnt_d;
    logic [WORD-1:0]     rd_data_q, rd_data_d;
    logic                rd_valid_q, rd_valid_d;
    logic [WORD-1:0]     mem_q [SIZE];

    logic                idle, clearing, wr_ok, rd_ok, rd_in_range;
    logic [LANES-1:0]    mem_we;
    logic [ADR_SIZE-1:0] mem_adr;
    logic [WORD-1:0]     mem_wdata;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (clear_i) begin
                    state_d = StClear;
                    cnt_d   = '0;
                end
            end
            StClear: begin
                if (cnt_q == LAST) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        idle     = (state_q == StIdle);
        clearing = (state_q == StClear);
        busy_o   = clearing;
    end

    assign wr_ok       = idle && wr_i && ({1'b0, wr_adr_i} < SIZE_W);
    assign rd_ok       = idle && rd_i;
    assign rd_in_range = ({1'b0, rd_adr_i} < SIZE_W);

    // The sweep owns the write port; user writes are ignored while clearing.
    always_comb begin
        mem_we    = '0;
        mem_adr   = wr_adr_i;
        mem_wdata = wr_data_i;
        if (clearing) begin
            mem_we    = '1;
            mem_adr   = cnt_q;
            mem_wdata = CLEAR_VAL;
        end else if (wr_ok) begin
            mem_we = wr_be_i;
        end
    end

    always_ff @(posedge clk_i) begin
        for (int k = 0; k < LANES; k++) begin
            if (mem_we[k]) begin
                mem_q[mem_adr][k*LW +: LW] <= mem_wdata[k*LW +: LW];
            end
        end
    end

    always_comb begin
        rd_valid_d = rd_ok;
        rd_data_d  = rd_data_q;
        if (rd_ok) begin
            rd_data_d = '0;
            if (rd_in_range) begin
                rd_data_d = mem_q[rd_adr_i];
`ifdef MEM_BYPASS_EN
                if (wr_ok && (wr_adr_i == rd_adr_i)) begin
                    for (int k = 0; k < LANES; k++) begin
                        if (wr_be_i[k]) begin
                            rd_data_d[k*LW +: LW] = wr_data_i[k*LW +: LW];
                        end
                    end
                end
`else
                // Read-first: the array still holds the pre-write word here.
`endif
            end
        end
    end

    assign rd_data_o  = rd_data_q;
    assign rd_valid_o = rd_valid_q;

endmodule

// File: doc/memory_dp_clr.md
Name: memory_dp_clr

Overview:
Parametrised simple-dual-port on-chip RAM with one write port and one read port, both on a single clock. Successor to the single-port combinational-read memory used for pixel/line storage in the Avalon-ST edge-detection datapath. Adds:
- per-lane write enables
- registered read with valid flag
- a working hardware clear sequencer
- out-of-range address protection

Parameters:
WORD, 8, data width in bits; must be a multiple of LANES.
SIZE, 256, number of words; need not be a power of two.
LANES, 1, write-enable lanes; lane width LW = WORD/LANES.
CLEAR_VAL, 0, WORD-bit value written to every location by a clear sweep.

Ports:
clk_i  in  1  clock, rising edge.
rst_n_i  in  1  asynchronous active-low reset.
clear_i  in  1  start a clear sweep; pulse, sampled in IDLE only.
busy_o  out  1  high while a clear sweep is running.
wr_i  in  1  write strobe.
wr_adr_i  in  ADR_SIZE  write address; ADR_SIZE = max(1, $clog2(SIZE)).
wr_be_i  in  LANES  lane enables; bit k covers data bits [k*LW +: LW].
wr_data_i  in  WORD  write data.
rd_i  in  1  read strobe.
rd_adr_i  in  ADR_SIZE  read address.
rd_data_o  out  WORD  registered read data.
rd_valid_o  out  1  one-cycle pulse marking rd_data_o as new.

Behaviour:
- Single clock domain.
- Reset is asynchronous, active-low (rst_n_i).
- Reset values: FSM = IDLE, busy_o = 0, rd_valid_o = 0, rd_data_o = 0, sweep counter = 0. Array contents are not affected by reset.
- FSM states: IDLE and CLEAR.
  - IDLE -> CLEAR on the edge where clear_i = 1.
  - In CLEAR, CLEAR_VAL is written to address cnt on each cycle; cnt counts 0..SIZE-1.
  - CLEAR -> IDLE on the edge that writes SIZE-1.
  - busy_o is registered, high for exactly SIZE cycles starting the cycle after clear_i.
- During CLEAR:
  - wr_i, rd_i and clear_i are ignored.
  - rd_valid_o stays 0.
  - rd_data_o holds its last value.
  - A new clear_i does not restart the sweep.
- Write (IDLE, wr_i = 1): each lane k with wr_be_i[k] = 1 updates that lane at wr_adr_i on the clock edge. Other lanes are unchanged. wr_be_i = 0 means no change.
- Read (IDLE, rd_i = 1):
  - Latency is 1 cycle: rd_data_o = mem[rd_adr_i] after the edge, and rd_valid_o = 1 for that one cycle.
  - With rd_i = 0, rd_valid_o = 0 and rd_data_o holds.
- Out of range (address >= SIZE): the write is dropped; the read returns 0 with rd_valid_o = 1.
- Same-cycle events in IDLE:
  - clear_i with wr_i or rd_i: the write and read complete on that edge, then the sweep starts. rd_valid_o pulses during the first busy cycle.
  - wr_i and rd_i at different addresses: both take effect, independently.
  - wr_i and rd_i at the same address: see Optional Feature.
- Reset mid-sweep: the sweep aborts immediately. Partially cleared contents remain. The block returns to IDLE with busy_o = 0.

Optional Feature:
MEM_BYPASS_EN. Applies to a same-address write and read in the same cycle.
- Defined: rd_data_o returns the merged data. Lanes with wr_be_i = 1 take wr_data_i; the other lanes take the old contents (write-first).
- Undefined: rd_data_o returns the old contents of the whole word (read-first).
- Write behaviour is identical in both builds.

Test Plan:
1. Defaults. Reset, write addr 5 = 0xA5 (be = 1), read addr 5 the next cycle -> rd_data_o = 0xA5 one cycle after rd_i, rd_valid_o high exactly 1 cycle; busy_o = 0 throughout.
2. WORD = 16, LANES = 2. Write addr 3 = 0x1234 (be = 2'b11), then write 0xABCD with be = 2'b10, then read addr 3 -> 0xAB34.
3. Fill addr 0..255 with addr^0xFF, then pulse clear_i -> busy_o high exactly 256 cycles. rd_i/wr_i asserted during busy -> no rd_valid_o and no effect. Afterwards, reads of addr 0, 128, 255 -> 0x00; with CLEAR_VAL = 0x5A -> 0x5A.
4. Addr 7 holds 0x11. Same cycle: write 0x22 and read addr 7 -> 0x11 without MEM_BYPASS_EN, 0x22 with it. The next read of addr 7 -> 0x22 in both builds.
5. Start a clear, assert rst_n_i low when cnt = 100 -> busy_o = 0 and rd_valid_o = 0 immediately. After release, addr 0..99 read 0x00 and addr 100..255 keep their old data. A new clear_i completes in the full 256 cycles.
6. SIZE = 200. Write addr 210 = 0x77 is dropped; read addr 210 -> 0x00 with rd_valid_o = 1; addr 199 stays readable and writable.
